// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the decode-stage branch stall controller.
package branch_ctrl_pkg;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Bubbles needed before the branch operand becomes forwardable.
  localparam logic [1:0] LD_DX  = 2'd2;
  localparam logic [1:0] ALU_DX = 2'd1;
  localparam logic [1:0] LD_EM  = 2'd1;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MW = 2'b01,
    FWD_EM = 2'b10
  } fwd_e;
endpackage

// File: rtl/branch_stall_ctrl_if.sv
// Pipeline-side view of the branch stall controller: producer info in, control out.
interface branch_stall_ctrl_if #(
  parameter int REG_AW = branch_ctrl_pkg::REG_AW,
  parameter int PERF_W = 16
) ();
  logic              branch_valid_FD;
  logic [REG_AW-1:0] Rs_FD;
  logic              RegWrite_DX, MemRead_DX;
  logic [REG_AW-1:0] Rd_DX;
  logic              RegWrite_EM, MemRead_EM;
  logic [REG_AW-1:0] Rd_EM;
  logic              RegWrite_MW;
  logic [REG_AW-1:0] Rd_MW;
  logic              branch_taken;
  logic              mem_stall;
  logic              stall_FD, bubble_DX, flush_FD;
  logic [1:0]        forward;
  logic [PERF_W-1:0] stall_cycles;

  modport slave (
    input  branch_valid_FD, Rs_FD, RegWrite_DX, MemRead_DX, Rd_DX,
           RegWrite_EM, MemRead_EM, Rd_EM, RegWrite_MW, Rd_MW,
           branch_taken, mem_stall,
    output stall_FD, bubble_DX, flush_FD, forward, stall_cycles
  );

  modport master (
    output branch_valid_FD, Rs_FD, RegWrite_DX, MemRead_DX, Rd_DX,
           RegWrite_EM, MemRead_EM, Rd_EM, RegWrite_MW, Rd_MW,
           branch_taken, mem_stall,
    input  stall_FD, bubble_DX, flush_FD, forward, stall_cycles
  );
endinterface

// File: rtl/branch_hazard_detect.sv
// Combinational Rs-vs-Rd compare: classifies the branch hazard and picks the operand source.
module branch_hazard_detect #(
  parameter int REG_AW = branch_ctrl_pkg::REG_AW
) (
  input  logic              branch_valid_FD,
  input  logic [REG_AW-1:0] Rs_FD,
  input  logic              RegWrite_DX,
  input  logic              MemRead_DX,
  input  logic [REG_AW-1:0] Rd_DX,
  input  logic              RegWrite_EM,
  input  logic              MemRead_EM,
  input  logic [REG_AW-1:0] Rd_EM,
  input  logic              RegWrite_MW,
  input  logic [REG_AW-1:0] Rd_MW,
  output logic              hazard,
  output logic [1:0]        waitLen,
  output logic [1:0]        forward
);
  import branch_ctrl_pkg::*;

  logic matchDx, matchEm, matchMw;
  logic hazLdDx, hazAluDx, hazLdEm;

  assign matchDx = (Rd_DX == Rs_FD);
  assign matchEm = (Rd_EM == Rs_FD);
  assign matchMw = (Rd_MW == Rs_FD);

  assign hazLdDx  = branch_valid_FD & RegWrite_DX &  MemRead_DX & matchDx;
  assign hazAluDx = branch_valid_FD & RegWrite_DX & ~MemRead_DX & matchDx;
  // An EM load only matters when nothing younger in DX already forces a wait.
  assign hazLdEm  = branch_valid_FD & RegWrite_EM & MemRead_EM & matchEm & ~(hazLdDx | hazAluDx);

  assign hazard = hazLdDx | hazAluDx | hazLdEm;

  always_comb begin
    waitLen = 2'd0;
    if (hazLdDx)       waitLen = LD_DX;
    else if (hazAluDx) waitLen = ALU_DX;
    else if (hazLdEm)  waitLen = LD_EM;
  end

  always_comb begin
    forward = FWD_RF;
    if (RegWrite_EM & matchEm & ~MemRead_EM) forward = FWD_EM;
    else if (RegWrite_MW & matchMw)          forward = FWD_MW;
  end
endmodule

// File: rtl/branch_stall_ctrl.sv
// Decode-stage branch controller: stalls on unforwardable operands, flushes on taken branches.
module branch_stall_ctrl #(
  parameter int REG_AW = branch_ctrl_pkg::REG_AW,
  parameter int PERF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_stall_ctrl_if.slave bus
);
  import branch_ctrl_pkg::*;

  state_e            state, stateNxt;
  logic [1:0]        cnt, cntNxt;
  logic [PERF_W-1:0] stallCycles;
  logic              hazard;
  logic [1:0]        waitLen;
  logic              stallFd, bubbleDx, flushFd;

  branch_hazard_detect #(.REG_AW(REG_AW)) uDetect (
    .branch_valid_FD (bus.branch_valid_FD),
    .Rs_FD           (bus.Rs_FD),
    .RegWrite_DX     (bus.RegWrite_DX),
    .MemRead_DX      (bus.MemRead_DX),
    .Rd_DX           (bus.Rd_DX),
    .RegWrite_EM     (bus.RegWrite_EM),
    .MemRead_EM      (bus.MemRead_EM),
    .Rd_EM           (bus.Rd_EM),
    .RegWrite_MW     (bus.RegWrite_MW),
    .Rd_MW           (bus.Rd_MW),
    .hazard          (hazard),
    .waitLen         (waitLen),
    .forward         (bus.forward)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      stallCycles <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (!bus.mem_stall && state == STALL && stallCycles != '1)
        stallCycles <= stallCycles + PERF_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    stallFd  = 1'b0;
    bubbleDx = 1'b0;
    flushFd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hazard) begin
          stateNxt = STALL;
          cntNxt   = waitLen;
        end else if (bus.branch_valid_FD && bus.branch_taken) begin
          stateNxt = FLUSH;
        end
      end
      STALL: begin
        stallFd  = 1'b1;
        bubbleDx = 1'b1;
        cntNxt   = cnt - 2'd1;
        // Back to IDLE so the branch re-evaluates with its producer now forwardable.
        if (cnt == 2'd1) stateNxt = IDLE;
      end
      FLUSH: begin
        flushFd  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    // A memory freeze overrides everything; a pending flush waits for the thaw.
    if (bus.mem_stall) begin
      stateNxt = state;
      cntNxt   = cnt;
      stallFd  = 1'b1;
      bubbleDx = 1'b0;
      flushFd  = 1'b0;
    end
  end

  assign bus.stall_FD     = stallFd;
  assign bus.bubble_DX    = bubbleDx;
  assign bus.flush_FD     = flushFd;
  assign bus.stall_cycles = stallCycles;
endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed-vector bench with a scoreboard queue; a second instance uses a 2-bit counter to reach saturation.
module tb_branch_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       bv, rwDx, mrDx, rwEm, mrEm, rwMw, tk, ms;
  logic [2:0] rs, rdDx, rdEm, rdMw;

  branch_stall_ctrl_if #(.REG_AW(3), .PERF_W(16)) bus  ();
  branch_stall_ctrl_if #(.REG_AW(3), .PERF_W(2))  bus2 ();

  assign bus.branch_valid_FD  = bv;   assign bus2.branch_valid_FD = bv;
  assign bus.Rs_FD            = rs;   assign bus2.Rs_FD           = rs;
  assign bus.RegWrite_DX      = rwDx; assign bus2.RegWrite_DX     = rwDx;
  assign bus.MemRead_DX       = mrDx; assign bus2.MemRead_DX      = mrDx;
  assign bus.Rd_DX            = rdDx; assign bus2.Rd_DX           = rdDx;
  assign bus.RegWrite_EM      = rwEm; assign bus2.RegWrite_EM     = rwEm;
  assign bus.MemRead_EM       = mrEm; assign bus2.MemRead_EM      = mrEm;
  assign bus.Rd_EM            = rdEm; assign bus2.Rd_EM           = rdEm;
  assign bus.RegWrite_MW      = rwMw; assign bus2.RegWrite_MW     = rwMw;
  assign bus.Rd_MW            = rdMw; assign bus2.Rd_MW           = rdMw;
  assign bus.branch_taken     = tk;   assign bus2.branch_taken    = tk;
  assign bus.mem_stall        = ms;   assign bus2.mem_stall       = ms;

  branch_stall_ctrl #(.REG_AW(3), .PERF_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  branch_stall_ctrl #(.REG_AW(3), .PERF_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    string      nm;
    logic       s, b, f;
    logic [1:0] fw;
    int         c, c2;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, string fld, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, expv);
    end
  endfunction

  // dx/em = {RegWrite, MemRead, Rd}, mw = {RegWrite, Rd}
  task automatic vec(input string nm, input logic rst, input logic bvI, input logic [2:0] rsI,
                     input logic [4:0] dx, input logic [4:0] em, input logic [3:0] mw,
                     input logic tkI, input logic msI,
                     input logic s, input logic b, input logic f, input logic [1:0] fw,
                     input int c, input int c2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    bv = bvI; rs = rsI;
    {rwDx, mrDx, rdDx} = dx;
    {rwEm, mrEm, rdEm} = em;
    {rwMw, rdMw} = mw;
    tk = tkI; ms = msI;
    e.nm = nm; e.s = s; e.b = b; e.f = f; e.fw = fw; e.c = c; e.c2 = c2;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.nm, "stall_FD",  int'(bus.stall_FD),  int'(e.s));
        chk(e.nm, "bubble_DX", int'(bus.bubble_DX), int'(e.b));
        chk(e.nm, "flush_FD",  int'(bus.flush_FD),  int'(e.f));
        chk(e.nm, "forward",   int'(bus.forward),   int'(e.fw));
        chk(e.nm, "stall_cycles",   int'(bus.stall_cycles),  e.c);
        chk(e.nm, "stall_cycles_w2", int'(bus2.stall_cycles), e.c2);
      end
    end
  end

  initial begin
    {bv, rwDx, mrDx, rwEm, mrEm, rwMw, tk, ms} = '0;
    {rs, rdDx, rdEm, rdMw} = '0;
    //   name      rst bv rs  dx        em        mw       tk ms   s  b  f  fw     c  c2
    vec("reset0",  0, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 0, 0);
    vec("reset1",  0, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 0, 0);
    // load r3 in DX: two stall cycles, then forward from MW
    vec("ld3_a",   1, 1, 3, 5'b11011, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 0, 0);
    vec("ld3_b",   1, 1, 3, 5'b00000, 5'b11011, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 0, 0);
    vec("ld3_c",   1, 1, 3, 5'b00000, 5'b00000, 4'b1011, 0, 0,   1, 1, 0, 2'b01, 1, 1);
    vec("ld3_d",   1, 1, 3, 5'b00000, 5'b00000, 4'b1011, 0, 0,   0, 0, 0, 2'b01, 2, 2);
    // ALU r5 in DX: one stall cycle, then forward from EM
    vec("alu5_a",  1, 1, 5, 5'b10101, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 2, 2);
    vec("alu5_b",  1, 1, 5, 5'b00000, 5'b10101, 4'b0000, 0, 0,   1, 1, 0, 2'b10, 2, 2);
    vec("alu5_c",  1, 1, 5, 5'b00000, 5'b10101, 4'b0000, 0, 0,   0, 0, 0, 2'b10, 3, 3);
    vec("idle0",   1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 3, 3);
    // taken branch, no hazard: one flush cycle, DX match during FLUSH ignored
    vec("tk_a",    1, 1, 1, 5'b00000, 5'b00000, 4'b0000, 1, 0,   0, 0, 0, 2'b00, 3, 3);
    vec("tk_b",    1, 1, 2, 5'b10010, 5'b00000, 4'b0000, 0, 0,   0, 0, 1, 2'b00, 3, 3);
    vec("tk_c",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 3, 3);
    // load r4 in EM: one stall cycle
    vec("ldem_a",  1, 1, 4, 5'b00000, 5'b11100, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 3, 3);
    vec("ldem_b",  1, 1, 4, 5'b00000, 5'b00000, 4'b1100, 0, 0,   1, 1, 0, 2'b01, 3, 3);
    vec("ldem_c",  1, 1, 4, 5'b00000, 5'b00000, 4'b1100, 0, 0,   0, 0, 0, 2'b01, 4, 3);
    // DX load beats EM load: wait length 2
    vec("pri_a",   1, 1, 6, 5'b11110, 5'b11110, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 4, 3);
    vec("pri_b",   1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 4, 3);
    vec("pri_c",   1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 5, 3);
    vec("pri_d",   1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 6, 3);
    // mem_stall for 3 cycles inside a 2-cycle load stall
    vec("ms_a",    1, 1, 3, 5'b11011, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 6, 3);
    vec("ms_b",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 1,   1, 0, 0, 2'b00, 6, 3);
    vec("ms_c",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 1,   1, 0, 0, 2'b00, 6, 3);
    vec("ms_d",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 1,   1, 0, 0, 2'b00, 6, 3);
    vec("ms_e",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 6, 3);
    vec("ms_f",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 7, 3);
    vec("ms_g",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 8, 3);
    // frozen FLUSH is not consumed
    vec("fz_a",    1, 1, 1, 5'b00000, 5'b00000, 4'b0000, 1, 0,   0, 0, 0, 2'b00, 8, 3);
    vec("fz_b",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 1,   1, 0, 0, 2'b00, 8, 3);
    vec("fz_c",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 1, 2'b00, 8, 3);
    vec("fz_d",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 8, 3);
    vec("idle_ms", 1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 1,   1, 0, 0, 2'b00, 8, 3);
    // async reset in the middle of a stall
    vec("rs_a",    1, 1, 3, 5'b11011, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 8, 3);
    vec("rs_b",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 8, 3);
    vec("rs_c",    0, 1, 3, 5'b11011, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 0, 0);
    vec("rs_d",    1, 1, 3, 5'b11011, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 0, 0);
    vec("rs_e",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 0, 0);
    vec("rs_f",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   1, 1, 0, 2'b00, 1, 1);
    vec("rs_g",    1, 0, 0, 5'b00000, 5'b00000, 4'b0000, 0, 0,   0, 0, 0, 2'b00, 2, 2);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_stall_ctrl.md
BRANCH_STALL_CTRL -- requirements
Module: branch_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width.
REQ-002 SHALL have parameter PERF_W, default 16, stall-cycle counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port branch_valid_FD, input, 1, branch/jump-register in decode that reads Rs.
REQ-006 SHALL have port Rs_FD, input, REG_AW, register read by the decode-stage branch.
REQ-007 SHALL have ports RegWrite_DX, MemRead_DX (input, 1) and Rd_DX (input, REG_AW), the EX-stage producer.
REQ-008 SHALL have ports RegWrite_EM, MemRead_EM (input, 1) and Rd_EM (input, REG_AW), the MEM-stage producer.
REQ-009 SHALL have ports RegWrite_MW (input, 1) and Rd_MW (input, REG_AW), the WB-stage producer.
REQ-010 SHALL have port branch_taken, input, 1, comparator result, valid in the resolve cycle.
REQ-011 SHALL have port mem_stall, input, 1, data-memory busy; freezes the whole pipeline.
REQ-012 SHALL have port stall_FD, output, 1, hold PC and the FD register.
REQ-013 SHALL have port bubble_DX, output, 1, load a NOP into DX.
REQ-014 SHALL have port flush_FD, output, 1, squash the wrong-path instruction in FD.
REQ-015 SHALL have port forward, output, 2, branch operand select: 10 = EM, 01 = MW, 00 = register file.
REQ-016 SHALL have port stall_cycles, output, PERF_W, saturating count of hazard-stall cycles.

Function
REQ-017 SHALL implement the FSM states IDLE, STALL and FLUSH, plus a 2-bit down-counter cnt.
REQ-018 SHALL declare hazard_ld_dx when branch_valid_FD & RegWrite_DX & MemRead_DX & Rd_DX==Rs_FD; the wait length is 2.
REQ-019 SHALL declare hazard_alu_dx when branch_valid_FD & RegWrite_DX & !MemRead_DX & Rd_DX==Rs_FD; the wait length is 1.
REQ-020 SHALL declare hazard_ld_em when branch_valid_FD & RegWrite_EM & MemRead_EM & Rd_EM==Rs_FD, with no DX hazard; the wait length is 1.
REQ-021 SHALL apply priority DX hazard over EM hazard; only the highest-priority hazard sets cnt.
REQ-022 SHALL, in IDLE with any hazard, go to STALL with cnt set to the wait length.
REQ-023 SHALL, in IDLE with branch_valid_FD, no hazard and branch_taken=1, go to FLUSH; otherwise stay in IDLE.
REQ-024 SHALL, in STALL, assert stall_FD=1 and bubble_DX=1 and decrement cnt each cycle.
REQ-025 SHALL, in STALL with cnt==1, return to IDLE so the branch re-evaluates with forwarding legal.
REQ-026 SHALL, in FLUSH, assert flush_FD=1 for exactly one cycle, ignore branch_valid_FD and go to IDLE.
REQ-027 SHALL drive forward combinationally in every state: 10 if RegWrite_EM & Rd_EM==Rs_FD & !MemRead_EM; else 01 if RegWrite_MW & Rd_MW==Rs_FD; else 00.
REQ-028 SHALL, while mem_stall=1, hold state, cnt and stall_cycles.
REQ-029 SHALL, while mem_stall=1, force stall_FD=1, bubble_DX=0 and flush_FD=0.
REQ-030 SHALL treat a FLUSH cycle with mem_stall=1 as not consumed; flush_FD asserts on the first unfrozen cycle.
REQ-031 SHALL increment stall_cycles in each unfrozen STALL cycle and saturate at all-ones without wrap.
REQ-032 SHALL keep outputs stall_FD, bubble_DX and flush_FD low in IDLE when mem_stall=0.

Reset
REQ-033 SHALL, on rst_n=0 and asynchronously, force state=IDLE, cnt=0 and stall_cycles=0; with mem_stall=0, stall_FD, bubble_DX and flush_FD are 0.
REQ-034 SHALL, on reset mid-STALL or mid-FLUSH, abandon the operation; the first cycle after release is IDLE.

Structure
REQ-035 SHALL place the state encoding, the wait-length constants (LD_DX=2, ALU_DX=1, LD_EM=1) and REG_AW in shared package branch_ctrl_pkg.
REQ-036 SHALL isolate the combinational Rs-versus-Rd compares, hazard classification and forward select in the sub-module branch_hazard_detect.

Verification
REQ-037 SHALL cover: LD r3 in DX, branch reads r3 -> stall_FD and bubble_DX high for 2 cycles, then forward=01, stall_cycles=2.
REQ-038 SHALL cover: ADD r5 in DX, branch reads r5 -> 1 stall cycle, then forward=10.
REQ-039 SHALL cover: no match, branch_taken=1 -> no stall, flush_FD high exactly 1 cycle after, then IDLE.
REQ-040 SHALL cover: mem_stall=1 for 3 cycles during a 2-cycle load stall -> stall_FD high for 5 cycles total, cnt held, stall_cycles=2.
REQ-041 SHALL cover: rst_n low mid-STALL -> outputs 0 immediately, state IDLE, stall_cycles=0.
REQ-042 SHALL cover: stall_cycles preloaded near 16'hFFFF plus 3 stall cycles -> holds at 16'hFFFF.
